// File: rtl/decode_stage.sv
// Instruction-decode pipeline stage: splits the instruction word into ALU/memory/audio
// opcodes and builds forwarded operands, with valid/ready handshakes, load-use bubbles and flush.
module decode_stage #(
    parameter int REG_BITS = 3,
    parameter int CH_BITS  = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic                flush,
    output logic [REG_BITS-1:0] rf_sel1,
    output logic [REG_BITS-1:0] rf_sel2,
    input  logic [31:0]         rf_val1,
    input  logic [31:0]         rf_val2,
    input  logic [1:0]          ex_fwd_en,
    input  logic [REG_BITS-1:0] ex_fwd_reg,
    input  logic [31:0]         ex_fwd_data,
    input  logic [1:0]          wb_fwd_en,
    input  logic [REG_BITS-1:0] wb_fwd_reg,
    input  logic [31:0]         wb_fwd_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2:0]          alu_opcode,
    output logic [4:0]          mem_code,
    output logic [2:0]          audio_opcode,
    output logic [31:0]         operand1,
    output logic [31:0]         operand2,
    output logic [1:0]          wb_enable,
    output logic [REG_BITS-1:0] wb_reg,
    output logic [2:0]          wb_sel,
    output logic [CH_BITS-1:0]  audio_ch,
    output logic [31:0]         out_instr
);

    localparam int RS1_LO = 16 + REG_BITS;
    localparam int CH_LO  = 26 - CH_BITS;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ARITH,
        CLS_MOVE,
        CLS_MEM,
        CLS_AUDIO
    } instr_class_t;

    logic                imm_flag;
    logic [1:0]          itype;
    logic [2:0]          op;
    logic [15:0]         imm16;
    logic [REG_BITS-1:0] rs1;
    logic [REG_BITS-1:0] rs2;
    logic [CH_BITS-1:0]  chan;
    instr_class_t        cls;

    assign imm_flag = in_instr[31];
    assign itype    = in_instr[30:29];
    assign op       = in_instr[28:26];
    assign imm16    = in_instr[15:0];
    assign rs1      = in_instr[RS1_LO +: REG_BITS];
    assign rs2      = in_instr[16 +: REG_BITS];
    assign chan     = in_instr[CH_LO +: CH_BITS];
    assign rf_sel1  = rs1;
    assign rf_sel2  = rs2;

    always_comb begin
        cls = CLS_NOP;
        case (itype)
            2'b01:   cls = (op == 3'b101 || op == 3'b110 || op == 3'b111) ? CLS_MOVE : CLS_ARITH;
            2'b10:   cls = CLS_MEM;
            2'b11:   cls = CLS_AUDIO;
            default: cls = CLS_NOP;
        endcase
    end

    // Each 16-bit half picks its newest producer independently; EX is younger than WB.
    logic [31:0] src1;
    logic [31:0] src2;

    always_comb begin
        src1 = rf_val1;
        src2 = rf_val2;
        for (int h = 0; h < 2; h++) begin
            if (ex_fwd_en[h] && ex_fwd_reg == rs1)
                src1[h*16 +: 16] = ex_fwd_data[h*16 +: 16];
            else if (wb_fwd_en[h] && wb_fwd_reg == rs1)
                src1[h*16 +: 16] = wb_fwd_data[h*16 +: 16];
            if (ex_fwd_en[h] && ex_fwd_reg == rs2)
                src2[h*16 +: 16] = ex_fwd_data[h*16 +: 16];
            else if (wb_fwd_en[h] && wb_fwd_reg == rs2)
                src2[h*16 +: 16] = wb_fwd_data[h*16 +: 16];
        end
    end

    logic [2:0]         d_alu;
    logic [4:0]         d_mem;
    logic [2:0]         d_audio;
    logic [31:0]        d_op1;
    logic [31:0]        d_op2;
    logic [1:0]         d_wb_en;
    logic [2:0]         d_wb_sel;
    logic [CH_BITS-1:0] d_ch;

    always_comb begin
        d_alu    = '0;
        d_mem    = '0;
        d_audio  = '0;
        d_op1    = src1;
        d_op2    = src2;
        d_wb_en  = '0;
        d_wb_sel = '0;
        d_ch     = '0;
        case (cls)
            CLS_ARITH: begin
                d_alu    = op;
                d_wb_sel = 3'b100;
                d_wb_en  = 2'b11;
                if (imm_flag) d_op2 = {16'h0, imm16};
            end
            CLS_MOVE: begin
                d_wb_sel = 3'b001;
                if (op == 3'b101) begin
                    d_wb_en = 2'b01;
                    if (imm_flag) d_op2 = {16'h0, imm16};
                end else if (op == 3'b110) begin
                    d_wb_en = 2'b10;
                    if (imm_flag) d_op2 = {imm16, 16'h0};
                end else begin
                    d_wb_en = 2'b11;
                end
            end
            CLS_MEM: begin
                d_mem    = {op[2], op[1], op[1], op[0], op[0]};
                d_wb_sel = 3'b010;
                if (op == 3'b001)      d_wb_en = 2'b01;
                else if (op == 3'b010) d_wb_en = 2'b10;
                if (imm_flag) d_op2 = {16'h0, imm16};
            end
            CLS_AUDIO: begin
                d_audio = op;
                d_ch    = chan;
                if (imm_flag && op == 3'b100)      d_op1 = {imm16, 16'h0};
                else if (imm_flag && op == 3'b110) d_op1 = {8'h0, imm16, 8'h0};
            end
            default: ;
        endcase
    end

    // Only memory ops with a non-zero write mask (the two loads) can create a load-use stall.
    logic hazard;
    logic load_en;
    logic take;

    assign hazard  = in_valid && out_valid && wb_sel[1] && (|wb_enable) && (cls != CLS_NOP)
                     && (rs1 == wb_reg || rs2 == wb_reg);
    assign in_ready = (~out_valid | out_ready) & ~hazard & ~flush;
    assign load_en  = flush | ~out_valid | out_ready;
    assign take     = ~flush & in_valid & ~hazard & (cls != CLS_NOP);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid    <= 1'b0;
            alu_opcode   <= '0;
            mem_code     <= '0;
            audio_opcode <= '0;
            operand1     <= '0;
            operand2     <= '0;
            wb_enable    <= '0;
            wb_reg       <= '0;
            wb_sel       <= '0;
            audio_ch     <= '0;
            out_instr    <= '0;
        end else if (load_en) begin
            if (take) begin
                out_valid    <= 1'b1;
                alu_opcode   <= d_alu;
                mem_code     <= d_mem;
                audio_opcode <= d_audio;
                operand1     <= d_op1;
                operand2     <= d_op2;
                wb_enable    <= d_wb_en;
                wb_reg       <= rs1;
                wb_sel       <= d_wb_sel;
                audio_ch     <= d_ch;
                out_instr    <= in_instr;
            end else begin
                out_valid    <= 1'b0;
                alu_opcode   <= '0;
                mem_code     <= '0;
                audio_opcode <= '0;
                operand1     <= '0;
                operand2     <= '0;
                wb_enable    <= '0;
                wb_reg       <= '0;
                wb_sel       <= '0;
                audio_ch     <= '0;
                out_instr    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus randomized traffic checked against
// a transaction-level model of the decode rules, forwarding and handshake behaviour.
module tb_decode_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        flush;
    logic [2:0]  rf_sel1, rf_sel2;
    logic [31:0] rf_val1, rf_val2;
    logic [1:0]  ex_fwd_en, wb_fwd_en;
    logic [2:0]  ex_fwd_reg, wb_fwd_reg;
    logic [31:0] ex_fwd_data, wb_fwd_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  alu_opcode, audio_opcode, wb_sel, wb_reg;
    logic [4:0]  mem_code;
    logic [31:0] operand1, operand2, out_instr;
    logic [1:0]  wb_enable, audio_ch;

    logic [31:0] regs [8];
    assign rf_val1 = regs[rf_sel1];
    assign rf_val2 = regs[rf_sel2];

    // Second build with a narrow register file and a wide channel field.
    logic        p_in_valid, p_in_ready, p_out_valid;
    logic [31:0] p_in_instr, p_op1, p_op2, p_out_instr;
    logic [1:0]  p_sel1, p_sel2, p_wb_reg, p_wb_enable;
    logic [2:0]  p_alu, p_audio, p_wb_sel;
    logic [4:0]  p_mem;
    logic [3:0]  p_audio_ch;

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic        valid;
        logic [2:0]  alu;
        logic [4:0]  mem;
        logic [2:0]  aud;
        logic [1:0]  wben;
        logic [2:0]  wbreg;
        logic [2:0]  wbsel;
        logic [1:0]  ch;
        logic [31:0] instr;
        logic [31:0] op1;
        logic [31:0] op2;
    } bundle_t;

    decode_stage #(.REG_BITS(3), .CH_BITS(2)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .flush(flush), .rf_sel1(rf_sel1), .rf_sel2(rf_sel2),
        .rf_val1(rf_val1), .rf_val2(rf_val2), .ex_fwd_en(ex_fwd_en), .ex_fwd_reg(ex_fwd_reg),
        .ex_fwd_data(ex_fwd_data), .wb_fwd_en(wb_fwd_en), .wb_fwd_reg(wb_fwd_reg),
        .wb_fwd_data(wb_fwd_data), .out_valid(out_valid), .out_ready(out_ready),
        .alu_opcode(alu_opcode), .mem_code(mem_code), .audio_opcode(audio_opcode),
        .operand1(operand1), .operand2(operand2), .wb_enable(wb_enable), .wb_reg(wb_reg),
        .wb_sel(wb_sel), .audio_ch(audio_ch), .out_instr(out_instr)
    );

    decode_stage #(.REG_BITS(2), .CH_BITS(4)) dut2 (
        .clk(clk), .resetn(resetn), .in_valid(p_in_valid), .in_ready(p_in_ready),
        .in_instr(p_in_instr), .flush(1'b0), .rf_sel1(p_sel1), .rf_sel2(p_sel2),
        .rf_val1(32'h0), .rf_val2(32'h0), .ex_fwd_en(2'b00), .ex_fwd_reg(2'b00),
        .ex_fwd_data(32'h0), .wb_fwd_en(2'b00), .wb_fwd_reg(2'b00),
        .wb_fwd_data(32'h0), .out_valid(p_out_valid), .out_ready(1'b1),
        .alu_opcode(p_alu), .mem_code(p_mem), .audio_opcode(p_audio),
        .operand1(p_op1), .operand2(p_op2), .wb_enable(p_wb_enable), .wb_reg(p_wb_reg),
        .wb_sel(p_wb_sel), .audio_ch(p_audio_ch), .out_instr(p_out_instr)
    );

    // Source value as the spec describes it: start from the register file, let WB overwrite
    // a matching half, then let EX overwrite it again so EX ends up with priority.
    function automatic logic [31:0] ref_src(input int sel, input logic [31:0] rfv);
        logic [31:0] r;
        r = rfv;
        for (int h = 0; h < 2; h++) begin
            if (wb_fwd_en[h] && int'(wb_fwd_reg) == sel) r[h*16 +: 16] = wb_fwd_data[h*16 +: 16];
            if (ex_fwd_en[h] && int'(ex_fwd_reg) == sel) r[h*16 +: 16] = ex_fwd_data[h*16 +: 16];
        end
        return r;
    endfunction

    function automatic bundle_t ref_decode(input logic [31:0] ins);
        bundle_t     b;
        int          typ, op, rs1, rs2;
        logic        imm;
        logic [31:0] im;
        b   = '0;
        typ = int'((ins >> 29) & 32'd3);
        op  = int'((ins >> 26) & 32'd7);
        rs1 = int'((ins >> 19) & 32'd7);
        rs2 = int'((ins >> 16) & 32'd7);
        imm = ins[31];
        im  = ins & 32'h0000FFFF;
        if (typ == 0) return b;
        b.valid = 1'b1;
        b.instr = ins;
        b.wbreg = rs1[2:0];
        b.op1   = ref_src(rs1, regs[rs1]);
        b.op2   = ref_src(rs2, regs[rs2]);
        if (typ == 1 && op >= 5) begin
            b.wbsel = 3'b001;
            b.wben  = (op == 5) ? 2'b01 : (op == 6) ? 2'b10 : 2'b11;
            if (imm && op == 5) b.op2 = im;
            if (imm && op == 6) b.op2 = im << 16;
        end else if (typ == 1) begin
            b.alu   = op[2:0];
            b.wbsel = 3'b100;
            b.wben  = 2'b11;
            if (imm) b.op2 = im;
        end else if (typ == 2) begin
            b.mem   = {op[2], op[1], op[1], op[0], op[0]};
            b.wbsel = 3'b010;
            b.wben  = (op == 1) ? 2'b01 : (op == 2) ? 2'b10 : 2'b00;
            if (imm) b.op2 = im;
        end else begin
            b.aud = op[2:0];
            b.ch  = ins[25:24];
            if (imm && op == 4) b.op1 = im << 16;
            if (imm && op == 6) b.op1 = im << 8;
        end
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        ex_fwd_en = 2'b00;
        wb_fwd_en = 2'b00;
        step();
    endtask

    task automatic test_reset();
        resetn   = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'h2C080000;
        out_ready = 1'b1;
        repeat (2) step();
        checks++;
        if ({out_valid, alu_opcode, mem_code, audio_opcode, operand1, operand2, wb_enable,
             wb_reg, wb_sel, audio_ch, out_instr} !== '0)
            $display("[TB] FAIL reset_bundle: got instr=%h op1=%h op2=%h, required all zero",
                     out_instr, operand1, operand2);
        else passes++;
        checks++;
        if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b required 0", out_valid);
        else passes++;
        resetn = 1'b1;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) $display("[TB] FAIL first_valid: got %b required 1", out_valid);
        else passes++;
        checks++;
        if (alu_opcode !== 3'd3) $display("[TB] FAIL first_alu: got %0d required 3", alu_opcode);
        else passes++;
        checks++;
        if ({wb_enable, wb_sel} !== {2'b11, 3'b100})
            $display("[TB] FAIL first_wb: got en=%b sel=%b required en=11 sel=100", wb_enable, wb_sel);
        else passes++;
    endtask

    task automatic test_move_upper();
        idle();
        in_valid = 1'b1;
        in_instr = 32'hB800ABCD;
        step();
        in_valid = 1'b0;
        checks++;
        if (operand2 !== 32'hABCD0000) $display("[TB] FAIL movu_op2: got %h required ABCD0000", operand2);
        else passes++;
        checks++;
        if (operand1 !== regs[0]) $display("[TB] FAIL movu_op1: got %h required %h", operand1, regs[0]);
        else passes++;
        checks++;
        if ({wb_enable, wb_sel, alu_opcode} !== {2'b10, 3'b001, 3'b000})
            $display("[TB] FAIL movu_wb: got en=%b sel=%b alu=%0d required en=10 sel=001 alu=0",
                     wb_enable, wb_sel, alu_opcode);
        else passes++;
    endtask

    task automatic test_load_use();
        idle();
        in_valid = 1'b1;
        in_instr = 32'h44100000;
        step();
        in_instr = 32'h201A0000;
        #1;
        checks++;
        if (in_ready !== 1'b0) $display("[TB] FAIL lu_stall: in_ready got %b required 0", in_ready);
        else passes++;
        step();
        checks++;
        if ({out_valid, out_instr} !== 33'h0)
            $display("[TB] FAIL lu_bubble: got valid=%b instr=%h required 0/0", out_valid, out_instr);
        else passes++;
        wb_fwd_en   = 2'b01;
        wb_fwd_reg  = 3'd2;
        wb_fwd_data = 32'h12345678;
        #1;
        checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL lu_resume: in_ready got %b required 1", in_ready);
        else passes++;
        step();
        in_valid  = 1'b0;
        wb_fwd_en = 2'b00;
        checks++;
        if ({out_valid, out_instr} !== {1'b1, 32'h201A0000})
            $display("[TB] FAIL lu_issue: got valid=%b instr=%h required 1/201A0000", out_valid, out_instr);
        else passes++;
        checks++;
        if (operand2 !== {regs[2][31:16], 16'h5678})
            $display("[TB] FAIL lu_fwd_op2: got %h required %h", operand2, {regs[2][31:16], 16'h5678});
        else passes++;
        checks++;
        if (operand1 !== regs[3]) $display("[TB] FAIL lu_op1: got %h required %h", operand1, regs[3]);
        else passes++;
    endtask

    task automatic test_backpressure();
        idle();
        in_valid = 1'b1;
        in_instr = 32'h2C080000;
        step();
        out_ready = 1'b0;
        in_instr  = 32'h24100000;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) $display("[TB] FAIL bp_ready[%0d]: got %b required 0", i, in_ready);
            else passes++;
            step();
            checks++;
            if ({out_valid, out_instr, alu_opcode} !== {1'b1, 32'h2C080000, 3'd3})
                $display("[TB] FAIL bp_hold[%0d]: got valid=%b instr=%h required 1/2C080000", i, out_valid, out_instr);
            else passes++;
        end
        out_ready = 1'b1;
        step();
        checks++;
        if ({out_valid, out_instr} !== {1'b1, 32'h24100000})
            $display("[TB] FAIL bp_next: got valid=%b instr=%h required 1/24100000", out_valid, out_instr);
        else passes++;
        in_instr = 32'h28180000;
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_instr, alu_opcode} !== {32'h28180000, 3'd2})
            $display("[TB] FAIL bp_third: got instr=%h alu=%0d required 28180000/2", out_instr, alu_opcode);
        else passes++;
        step();
        checks++;
        if (out_valid !== 1'b0) $display("[TB] FAIL bp_drain: got %b required 0", out_valid);
        else passes++;
    endtask

    task automatic test_flush();
        idle();
        in_valid = 1'b1;
        in_instr = 32'h2C080000;
        step();
        out_ready = 1'b0;
        flush     = 1'b1;
        in_instr  = 32'h24100000;
        #1;
        checks++;
        if (in_ready !== 1'b0) $display("[TB] FAIL flush_ready: got %b required 0", in_ready);
        else passes++;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_instr, wb_enable} !== 35'h0)
            $display("[TB] FAIL flush_clear: got valid=%b instr=%h required 0/0", out_valid, out_instr);
        else passes++;
    endtask

    task automatic test_midstream_reset();
        idle();
        in_valid = 1'b1;
        in_instr = 32'h2C080000;
        step();
        in_valid = 1'b0;
        resetn   = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_instr} !== 33'h0)
            $display("[TB] FAIL async_reset: got valid=%b instr=%h required 0/0", out_valid, out_instr);
        else passes++;
        step();
        resetn   = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h24100000;
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_instr} !== {1'b1, 32'h24100000})
            $display("[TB] FAIL post_reset_accept: got valid=%b instr=%h required 1/24100000", out_valid, out_instr);
        else passes++;
    endtask

    task automatic test_param_build();
        p_in_valid = 1'b1;
        p_in_instr = 32'h628C0000;
        #1;
        checks++;
        if (p_sel1 !== 2'd3) $display("[TB] FAIL p2_sel1: got %0d required 3", p_sel1);
        else passes++;
        step();
        p_in_valid = 1'b0;
        checks++;
        if ({p_out_valid, p_audio_ch, p_wb_enable, p_alu} !== {1'b1, 4'hA, 2'b00, 3'd0})
            $display("[TB] FAIL p2_audio: got valid=%b ch=%h wben=%b required 1/A/00",
                     p_out_valid, p_audio_ch, p_wb_enable);
        else passes++;
    endtask

    task automatic test_random();
        bundle_t exp_b, nxt, obs;
        logic    exp_load, nxt_load, haz, exp_rdy;
        logic [31:0] r;
        int      typ, op, rs1, rs2;
        idle();
        for (int i = 0; i < 8; i++) regs[i] = $urandom;
        exp_b    = '0;
        exp_load = 1'b0;
        for (int n = 0; n < 600; n++) begin
            r = $urandom;
            if ($urandom_range(0, 3) == 0) r[30:26] = ($urandom_range(0, 1) == 1) ? 5'b10001 : 5'b10010;
            if ($urandom_range(0, 2) == 0) r[21:19] = exp_b.wbreg;
            in_instr    = r;
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 19) == 0);
            ex_fwd_en   = 2'($urandom_range(0, 3));
            wb_fwd_en   = 2'($urandom_range(0, 3));
            ex_fwd_reg  = 3'($urandom_range(0, 7));
            wb_fwd_reg  = 3'($urandom_range(0, 7));
            ex_fwd_data = $urandom;
            wb_fwd_data = $urandom;
            #1;
            typ = int'(r[30:29]);
            op  = int'(r[28:26]);
            rs1 = int'(r[21:19]);
            rs2 = int'(r[18:16]);
            haz = exp_b.valid && exp_load && in_valid && typ != 0
                  && (rs1 == int'(exp_b.wbreg) || rs2 == int'(exp_b.wbreg));
            exp_rdy = (!exp_b.valid || out_ready) && !haz && !flush;
            checks++;
            if (in_ready !== exp_rdy) $display("[TB] FAIL rand_in_ready[%0d]: got %b required %b", n, in_ready, exp_rdy);
            else passes++;
            nxt      = exp_b;
            nxt_load = exp_load;
            if (flush || (!exp_rdy && exp_b.valid && out_ready) || (!in_valid && out_ready)) begin
                nxt      = '0;
                nxt_load = 1'b0;
            end
            if (in_valid && exp_rdy) begin
                nxt      = ref_decode(r);
                nxt_load = (typ == 2) && (op == 1 || op == 2);
            end
            step();
            obs = {out_valid, alu_opcode, mem_code, audio_opcode, wb_enable, wb_reg, wb_sel,
                   audio_ch, out_instr, operand1, operand2};
            if (!nxt.valid) begin
                obs.op1 = '0;
                obs.op2 = '0;
            end
            checks++;
            if (obs !== nxt) $display("[TB] FAIL rand_bundle[%0d]: got %h required %h", n, obs, nxt);
            else passes++;
            exp_b    = nxt;
            exp_load = nxt_load;
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        ex_fwd_en = 2'b00;
        wb_fwd_en = 2'b00;
    endtask

    initial begin
        resetn      = 1'b0;
        in_valid    = 1'b0;
        in_instr    = '0;
        flush       = 1'b0;
        out_ready   = 1'b1;
        ex_fwd_en   = '0;
        ex_fwd_reg  = '0;
        ex_fwd_data = '0;
        wb_fwd_en   = '0;
        wb_fwd_reg  = '0;
        wb_fwd_data = '0;
        p_in_valid  = 1'b0;
        p_in_instr  = '0;
        for (int i = 0; i < 8; i++) regs[i] = 32'h1111_0000 * (i + 1) + i;
        regs[2] = 32'hAAAA_BBBB;
        regs[3] = 32'h3333_0003;
        test_reset();
        test_move_upper();
        test_load_use();
        test_backpressure();
        test_flush();
        test_midstream_reset();
        test_param_build();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
